multicore_mem_arbiter: RTL and testbench

Memory arbiter that shares the single RAM port among the instruction and data cache channels of `CPUS` cores. It is the multicore successor to the one-core memory control path and sits between the per-core cache blocks and the `cpu_ram_if` RAM port in the multicore top level. It adds fair round-robin arbitration, an optional data-first priority mode, held grants across RAM wait states, and aborted-request recovery.

---
 rtl/multicore_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_multicore_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicore_mem_arbiter.sv
// Shares one RAM port among the I/D cache channels of CPUS cores with round-robin arbitration.
// Channel 2c is core c's I-cache, 2c+1 its D-cache; RAM-side outputs are registered at grant time.
module multicore_mem_arbiter #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PRIO_D = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS*ADDR_W-1:0] iaddr,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS*ADDR_W-1:0] daddr,
    input  logic [CPUS*DATA_W-1:0] dstore,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS*DATA_W-1:0] iload,
    output logic [CPUS*DATA_W-1:0] dload,
    output logic [ADDR_W-1:0]      ramaddr,
    output logic [DATA_W-1:0]      ramstore,
    output logic                   ramREN,
    output logic                   ramWEN,
    input  logic [DATA_W-1:0]      ramload,
    input  logic [1:0]             ramstate
);
    localparam int N  = 2 * CPUS;
    localparam int PW = $clog2(N);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {IDLE, SERVE} state_t;

    state_t            state;
    logic [PW-1:0]     grant;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     idx;
    logic [PW-1:0]     grant_nxt;
    logic [N-1:0]      req;
    logic [N-1:0]      dmask;
    logic [N-1:0]      cand;
    logic [N-1:0]      ch_wr;
    logic [ADDR_W-1:0] ch_addr [N];
    logic [DATA_W-1:0] ch_data [N];
    logic              found;
    logic              done;

    for (genvar c = 0; c < CPUS; c++) begin : g_ch
        assign req[2*c]       = iREN[c];
        assign req[2*c+1]     = dREN[c] | dWEN[c];
        assign dmask[2*c]     = 1'b0;
        assign dmask[2*c+1]   = 1'b1;
        // A D channel with both enables high is treated as a write.
        assign ch_wr[2*c]     = 1'b0;
        assign ch_wr[2*c+1]   = dWEN[c];
        assign ch_addr[2*c]   = iaddr[c*ADDR_W +: ADDR_W];
        assign ch_addr[2*c+1] = daddr[c*ADDR_W +: ADDR_W];
        assign ch_data[2*c]   = '0;
        assign ch_data[2*c+1] = dstore[c*DATA_W +: DATA_W];
        assign iload[c*DATA_W +: DATA_W] = ramload;
        assign dload[c*DATA_W +: DATA_W] = ramload;
        assign iwait[c] = ~(done && (grant == PW'(2*c)));
        assign dwait[c] = ~(done && (grant == PW'(2*c+1)));
    end

    assign done      = (state == SERVE) && (ramstate == RAM_ACCESS);
    assign cand      = ((PRIO_D != 0) && |(req & dmask)) ? (req & dmask) : req;
    assign grant_nxt = (grant == PW'(N-1)) ? '0 : grant + 1'b1;

    // First candidate at or after rr_ptr, wrapping past N-1.
    always_comb begin : pick_search
        int j;
        j     = 0;
        idx   = '0;
        found = 1'b0;
        pick  = rr_ptr;
        for (int i = 0; i < N; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N) j = j - N;
            idx = PW'(j);
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            ramaddr  <= '0;
            ramstore <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= SERVE;
                        grant    <= pick;
                        ramaddr  <= ch_addr[pick];
                        ramstore <= ch_data[pick];
                        ramWEN   <= ch_wr[pick];
                        ramREN   <= ~ch_wr[pick];
                    end
                end
                SERVE: begin
                    // A completing ACCESS wins over a request dropped in the same cycle.
                    if (ramstate == RAM_ACCESS) begin
                        state  <= IDLE;
                        rr_ptr <= grant_nxt;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                    end else if (!req[grant]) begin
                        state  <= IDLE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Bench for multicore_mem_arbiter: a round-robin (PRIO_D=0) and a data-first (PRIO_D=1) instance
// share one stimulus stream; hand-derived vectors plus a transaction-level reference model.
module tb_multicore_mem_arbiter;
    localparam int N = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  iREN = '0, dREN = '0, dWEN = '0, ramstate = FREE;
    logic [63:0] iaddr = '0, daddr = '0, dstore = '0;
    logic [31:0] ramload = '0;

    logic [1:0]  iwait_o [2];
    logic [1:0]  dwait_o [2];
    logic [63:0] iload_o [2];
    logic [63:0] dload_o [2];
    logic [31:0] raddr_o [2];
    logic [31:0] rstore_o [2];
    logic        ren_o [2];
    logic        wen_o [2];

    int    checks = 0;
    int    errors = 0;
    string tag = "init";

    always #5 CLK = ~CLK;

    multicore_mem_arbiter #(.CPUS(2), .ADDR_W(32), .DATA_W(32), .PRIO_D(0)) u_rr (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait_o[0]), .dwait(dwait_o[0]),
        .iload(iload_o[0]), .dload(dload_o[0]), .ramaddr(raddr_o[0]), .ramstore(rstore_o[0]),
        .ramREN(ren_o[0]), .ramWEN(wen_o[0]), .ramload(ramload), .ramstate(ramstate));

    multicore_mem_arbiter #(.CPUS(2), .ADDR_W(32), .DATA_W(32), .PRIO_D(1)) u_pd (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait_o[1]), .dwait(dwait_o[1]),
        .iload(iload_o[1]), .dload(dload_o[1]), .ramaddr(raddr_o[1]), .ramstore(rstore_o[1]),
        .ramREN(ren_o[1]), .ramWEN(wen_o[1]), .ramload(ramload), .ramstate(ramstate));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: one outstanding transaction per instance ----------------
    bit          mbusy [2] = '{0, 0};
    int          mch   [2] = '{0, 0};
    int          mptr  [2] = '{0, 0};
    bit          mwen  [2] = '{0, 0};
    logic [31:0] maddr [2] = '{0, 0};
    logic [31:0] mst   [2] = '{0, 0};
    int          mp;
    logic [3:0]  ew;

    function automatic bit mreq(input int k);
        return (k % 2 == 0) ? iREN[k/2] : (dREN[k/2] | dWEN[k/2]);
    endfunction

    // Pending channel closest (cyclically) at or after the instance's pointer.
    function automatic int mpick(input int m);
        int best, bestd, d;
        bit anyd;
        best = -1; bestd = N; anyd = 0;
        for (int k = 1; k < N; k += 2) if (mreq(k)) anyd = 1;
        for (int k = 0; k < N; k++) begin
            d = (k - mptr[m] + N) % N;
            if (mreq(k) && !(m == 1 && anyd && k % 2 == 0) && d < bestd) begin
                best = k;
                bestd = d;
            end
        end
        return best;
    endfunction

    always @(posedge CLK or posedge RST) begin
        for (int m = 0; m < 2; m++) begin
            if (RST) begin
                mbusy[m] <= 0; mch[m] <= 0; mptr[m] <= 0; mwen[m] <= 0;
                maddr[m] <= '0; mst[m] <= '0;
            end else if (!mbusy[m]) begin
                mp = mpick(m);
                if (mp >= 0) begin
                    mbusy[m] <= 1;
                    mch[m]   <= mp;
                    maddr[m] <= (mp % 2 == 0) ? iaddr[(mp/2)*32 +: 32] : daddr[(mp/2)*32 +: 32];
                    mwen[m]  <= (mp % 2 == 1) && dWEN[mp/2];
                    mst[m]   <= (mp % 2 == 1) ? dstore[(mp/2)*32 +: 32] : 32'h0;
                end
            end else if (ramstate == ACC) begin
                mbusy[m] <= 0;
                mptr[m]  <= (mch[m] + 1) % N;
            end else if (!mreq(mch[m])) begin
                mbusy[m] <= 0;
            end
        end
    end

    always @(negedge CLK) begin
        for (int m = 0; m < 2; m++) begin
            ew = 4'hF;
            if (mbusy[m] && ramstate == ACC) ew[mch[m]] = 1'b0;
            chk($sformatf("model u%0d ramREN", m), ren_o[m], mbusy[m] && !mwen[m]);
            chk($sformatf("model u%0d ramWEN", m), wen_o[m], mbusy[m] && mwen[m]);
            chk($sformatf("model u%0d ramaddr", m), raddr_o[m], maddr[m]);
            chk($sformatf("model u%0d ramstore", m), rstore_o[m], mst[m]);
            chk($sformatf("model u%0d iwait", m), iwait_o[m], {ew[2], ew[0]});
            chk($sformatf("model u%0d dwait", m), dwait_o[m], {ew[3], ew[1]});
            chk($sformatf("model u%0d iload", m), iload_o[m], {ramload, ramload});
            chk($sformatf("model u%0d dload", m), dload_o[m], {ramload, ramload});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic setin(input logic [1:0] ir, input logic [1:0] dr, input logic [1:0] dw,
                         input logic [1:0] rs);
        iREN = ir; dREN = dr; dWEN = dw; ramstate = rs;
    endtask

    task automatic rst_pulse();
        RST = 1'b1;
        #2;
        RST = 1'b0;
    endtask

    task automatic step(input int m, input logic [1:0] eiw, input logic [1:0] edw,
                        input logic eren, input logic ewen, input logic [31:0] ea,
                        input logic [31:0] es);
        @(negedge CLK);
        chk($sformatf("%s u%0d iwait", tag, m), iwait_o[m], eiw);
        chk($sformatf("%s u%0d dwait", tag, m), dwait_o[m], edw);
        chk($sformatf("%s u%0d ramREN", tag, m), ren_o[m], eren);
        chk($sformatf("%s u%0d ramWEN", tag, m), wen_o[m], ewen);
        chk($sformatf("%s u%0d ramaddr", tag, m), raddr_o[m], ea);
        chk($sformatf("%s u%0d ramstore", tag, m), rstore_o[m], es);
        nxt();
    endtask

    typedef struct {
        logic [1:0]  ir, dr, dw, rs;
        logic [1:0]  eiw, edw;
        logic        eren;
        logic [31:0] eaddr;
    } row_t;
    row_t tbl [11];

    initial begin
        int r;
        // Four-channel round robin with every access completing on its first SERVE cycle.
        tbl[0]  = '{2'b11, 2'b11, 2'b00, ACC, 2'b11, 2'b11, 1'b0, 32'h0};
        tbl[1]  = '{2'b11, 2'b11, 2'b00, ACC, 2'b10, 2'b11, 1'b1, 32'h1000};
        tbl[2]  = '{2'b11, 2'b11, 2'b00, ACC, 2'b11, 2'b11, 1'b0, 32'h1000};
        tbl[3]  = '{2'b11, 2'b11, 2'b00, ACC, 2'b11, 2'b10, 1'b1, 32'h2000};
        tbl[4]  = '{2'b11, 2'b11, 2'b00, ACC, 2'b11, 2'b11, 1'b0, 32'h2000};
        tbl[5]  = '{2'b11, 2'b11, 2'b00, ACC, 2'b01, 2'b11, 1'b1, 32'h1004};
        tbl[6]  = '{2'b11, 2'b11, 2'b00, ACC, 2'b11, 2'b11, 1'b0, 32'h1004};
        tbl[7]  = '{2'b11, 2'b11, 2'b00, ACC, 2'b11, 2'b01, 1'b1, 32'h2004};
        tbl[8]  = '{2'b11, 2'b11, 2'b00, ACC, 2'b11, 2'b11, 1'b0, 32'h2004};
        tbl[9]  = '{2'b11, 2'b11, 2'b00, ACC, 2'b10, 2'b11, 1'b1, 32'h1000};
        tbl[10] = '{2'b00, 2'b00, 2'b00, ACC, 2'b11, 2'b11, 1'b0, 32'h1000};

        iaddr  = {32'h1004, 32'h1000};
        daddr  = {32'h2004, 32'h2000};
        dstore = {32'hB0B0B0B0, 32'hA0A0A0A0};
        nxt();
        nxt();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("reset u%0d ramREN", m), ren_o[m], 1'b0);
            chk($sformatf("reset u%0d ramWEN", m), wen_o[m], 1'b0);
            chk($sformatf("reset u%0d ramaddr", m), raddr_o[m], 32'h0);
            chk($sformatf("reset u%0d ramstore", m), rstore_o[m], 32'h0);
            chk($sformatf("reset u%0d iwait", m), iwait_o[m], 2'b11);
            chk($sformatf("reset u%0d dwait", m), dwait_o[m], 2'b11);
        end
        RST = 1'b0;

        tag = "table";
        for (int i = 0; i < 11; i++) begin
            setin(tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].rs);
            @(negedge CLK);
            chk($sformatf("table[%0d] iwait", i), iwait_o[0], tbl[i].eiw);
            chk($sformatf("table[%0d] dwait", i), dwait_o[0], tbl[i].edw);
            chk($sformatf("table[%0d] ramREN", i), ren_o[0], tbl[i].eren);
            chk($sformatf("table[%0d] ramaddr", i), raddr_o[0], tbl[i].eaddr);
            nxt();
        end

        // Data-first: channel 3 before the I channels, then I channels 0 and 2 in turn.
        tag = "prio";
        rst_pulse();
        setin(2'b11, 2'b10, 2'b00, ACC);
        step(1, 2'b11, 2'b11, 0, 0, 32'h0, 32'h0);
        step(1, 2'b11, 2'b01, 1, 0, 32'h2004, 32'hB0B0B0B0);
        setin(2'b11, 2'b00, 2'b00, ACC);
        step(1, 2'b11, 2'b11, 0, 0, 32'h2004, 32'hB0B0B0B0);
        step(1, 2'b10, 2'b11, 1, 0, 32'h1000, 32'h0);
        step(1, 2'b11, 2'b11, 0, 0, 32'h1000, 32'h0);
        step(1, 2'b01, 2'b11, 1, 0, 32'h1004, 32'h0);
        setin(2'b00, 2'b00, 2'b00, FREE);
        step(1, 2'b11, 2'b11, 0, 0, 32'h1004, 32'h0);

        // Write held across three BUSY cycles; dREN and dWEN both high means write.
        tag = "write";
        rst_pulse();
        daddr[31:0]  = 32'h40;
        dstore[31:0] = 32'hDEADBEEF;
        setin(2'b00, 2'b01, 2'b01, BUSY);
        step(0, 2'b11, 2'b11, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 2'b11, 2'b11, 0, 1, 32'h40, 32'hDEADBEEF);
        ramstate = ACC;
        step(0, 2'b11, 2'b10, 0, 1, 32'h40, 32'hDEADBEEF);
        setin(2'b00, 2'b00, 2'b00, BUSY);
        step(0, 2'b11, 2'b11, 0, 0, 32'h40, 32'hDEADBEEF);
        daddr  = {32'h2004, 32'h2000};
        dstore = {32'hB0B0B0B0, 32'hA0A0A0A0};

        // Abort of channel 2 with the pointer at 2: next grant is channel 3, not channel 0/1.
        tag = "abort";
        setin(2'b10, 2'b00, 2'b00, BUSY);
        step(0, 2'b11, 2'b11, 0, 0, 32'h40, 32'hDEADBEEF);
        step(0, 2'b11, 2'b11, 1, 0, 32'h1004, 32'h0);
        setin(2'b01, 2'b11, 2'b00, BUSY);
        step(0, 2'b11, 2'b11, 1, 0, 32'h1004, 32'h0);
        step(0, 2'b11, 2'b11, 0, 0, 32'h1004, 32'h0);
        ramstate = ACC;
        step(0, 2'b11, 2'b01, 1, 0, 32'h2004, 32'hB0B0B0B0);
        setin(2'b00, 2'b00, 2'b00, FREE);
        step(0, 2'b11, 2'b11, 0, 0, 32'h2004, 32'hB0B0B0B0);

        // ERROR is a retry: wait stays high until ACCESS, load data visible then.
        tag = "error";
        rst_pulse();
        ramload = 32'h1234;
        setin(2'b01, 2'b00, 2'b00, ERR);
        step(0, 2'b11, 2'b11, 0, 0, 32'h0, 32'h0);
        step(0, 2'b11, 2'b11, 1, 0, 32'h1000, 32'h0);
        step(0, 2'b11, 2'b11, 1, 0, 32'h1000, 32'h0);
        ramstate = ACC;
        @(negedge CLK);
        chk("error iwait", iwait_o[0], 2'b10);
        chk("error iload0", iload_o[0][31:0], 32'h1234);
        chk("error iload1", iload_o[0][63:32], 32'h1234);
        nxt();
        setin(2'b00, 2'b00, 2'b00, FREE);
        step(0, 2'b11, 2'b11, 0, 0, 32'h1000, 32'h0);

        // Reset during a write: outputs cleared, pointer back to 0, write retried later.
        tag = "rstmid";
        rst_pulse();
        setin(2'b10, 2'b00, 2'b00, ACC);
        step(0, 2'b11, 2'b11, 0, 0, 32'h0, 32'h0);
        step(0, 2'b01, 2'b11, 1, 0, 32'h1004, 32'h0);
        setin(2'b00, 2'b00, 2'b10, BUSY);
        step(0, 2'b11, 2'b11, 0, 0, 32'h1004, 32'h0);
        step(0, 2'b11, 2'b11, 0, 1, 32'h2004, 32'hB0B0B0B0);
        RST = 1'b1;
        #1;
        chk("rstmid ramWEN", wen_o[0], 1'b0);
        chk("rstmid ramREN", ren_o[0], 1'b0);
        chk("rstmid ramaddr", raddr_o[0], 32'h0);
        chk("rstmid iwait", iwait_o[0], 2'b11);
        chk("rstmid dwait", dwait_o[0], 2'b11);
        RST = 1'b0;
        setin(2'b00, 2'b01, 2'b10, ACC);
        step(0, 2'b11, 2'b11, 0, 0, 32'h0, 32'h0);
        step(0, 2'b11, 2'b10, 1, 0, 32'h2000, 32'hA0A0A0A0);
        dREN = 2'b00;
        step(0, 2'b11, 2'b11, 0, 0, 32'h2000, 32'hA0A0A0A0);
        step(0, 2'b11, 2'b01, 0, 1, 32'h2004, 32'hB0B0B0B0);
        setin(2'b00, 2'b00, 2'b00, FREE);
        step(0, 2'b11, 2'b11, 0, 0, 32'h2004, 32'hB0B0B0B0);

        // Random traffic, checked by the reference model every cycle.
        tag = "random";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) iREN = iREN ^ 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) dREN = dREN ^ 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) dWEN = dWEN ^ 2'($urandom_range(0, 3));
            r = int'($urandom_range(0, 7));
            ramstate = (r < 4) ? ACC : 2'(r);
            iaddr   = {$urandom, $urandom};
            daddr   = {$urandom, $urandom};
            dstore  = {$urandom, $urandom};
            ramload = $urandom;
            if ($urandom_range(0, 199) == 0) rst_pulse();
            nxt();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
